// File: rtl/csi_frame_fmt.sv
// CSI-2 frame formatter: per-VC frame tracking, skip, measurement and a framed pixel stream.
// Latency 2 cycles from accepted beat / FE header to output; no backpressure, the sink takes every beat.
module csi_frame_fmt #(
  parameter  int DATA_W      = 32,
  parameter  int NUM_VC      = 1,
  parameter  int SKIP_FRAMES = 4,
  parameter  int CNT_W       = 16,
  localparam int BYTES       = DATA_W / 8
) (
  input  logic                    pixel_clk,
  input  logic                    reset_n,
  input  logic                    hdr_vld,
  input  logic [5:0]              hdr_dt,
  input  logic [1:0]              hdr_vc,
  input  logic [15:0]             hdr_wc,
  input  logic                    dat_vld,
  input  logic [DATA_W-1:0]       dat_i,
  output logic                    out_vld,
  output logic [DATA_W-1:0]       out_dat,
  output logic [BYTES-1:0]        out_keep,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic [1:0]              out_vc,
  output logic [NUM_VC*CNT_W-1:0] img_hbytes,
  output logic [NUM_VC*CNT_W-1:0] img_vlines,
  output logic [2:0]              err
);

  localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  typedef enum logic {IDLE, PAYLOAD} pkt_st_t;

  pkt_st_t state_q, state_d;
  logic [1:0]  pkt_vc_q, pkt_vc_d;
  logic [15:0] pkt_wc_q, pkt_wc_d;
  logic [15:0] beats_q, beats_d;
  logic        pkt_act_q, pkt_act_d, pkt_en_q, pkt_en_d;

  logic [NUM_VC-1:0] in_frame_q, in_frame_d, sof_pend_q, sof_pend_d, en_q, en_d;
  logic [NUM_VC-1:0][CNT_W-1:0] line_cnt_q, line_cnt_d, first_len_q, first_len_d;
  logic [NUM_VC-1:0][CNT_W-1:0] img_h_q, img_h_d, img_v_q, img_v_d;
  logic [NUM_VC-1:0][SKW-1:0]   skip_q, skip_d;

  logic              s1_vld_q, s1_vld_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
  logic [DATA_W-1:0] s1_dat_q, s1_dat_d;
  logic [BYTES-1:0]  s1_keep_q, s1_keep_d, last_keep;
  logic [1:0]        s1_vc_q, s1_vc_d;
  logic [2:0]        s1_err_q, s1_err_d;
  logic [15:0]       rem, beats_new;

  logic hdr_ok, is_fs, is_fe, is_long, start_pkt, beat, last_beat;

  // Headers addressed to an untracked VC are invisible, including to truncation.
  assign hdr_ok    = hdr_vld && (int'(hdr_vc) < NUM_VC);
  assign is_fs     = (hdr_dt == 6'h00);
  assign is_fe     = (hdr_dt == 6'h01);
  assign is_long   = (hdr_dt >= 6'h10);
  assign start_pkt = hdr_ok && is_long && (hdr_wc != 16'd0);
  assign beat      = (state_q == PAYLOAD) && dat_vld && !hdr_ok;
  assign last_beat = beat && (beats_q == 16'd1);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pkt_vc_q    <= '0;
      pkt_wc_q    <= '0;
      beats_q     <= '0;
      pkt_act_q   <= 1'b0;
      pkt_en_q    <= 1'b0;
      in_frame_q  <= '0;
      sof_pend_q  <= '0;
      en_q        <= '0;
      line_cnt_q  <= '0;
      first_len_q <= '0;
      img_h_q     <= '0;
      img_v_q     <= '0;
      skip_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_dat_q    <= '0;
      s1_keep_q   <= '0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_vc_q     <= '0;
      s1_err_q    <= '0;
      out_vld     <= 1'b0;
      out_dat     <= '0;
      out_keep    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
      out_vc      <= '0;
      err         <= '0;
    end else begin
      state_q     <= state_d;
      pkt_vc_q    <= pkt_vc_d;
      pkt_wc_q    <= pkt_wc_d;
      beats_q     <= beats_d;
      pkt_act_q   <= pkt_act_d;
      pkt_en_q    <= pkt_en_d;
      in_frame_q  <= in_frame_d;
      sof_pend_q  <= sof_pend_d;
      en_q        <= en_d;
      line_cnt_q  <= line_cnt_d;
      first_len_q <= first_len_d;
      img_h_q     <= img_h_d;
      img_v_q     <= img_v_d;
      skip_q      <= skip_d;
      s1_vld_q    <= s1_vld_d;
      s1_dat_q    <= s1_dat_d;
      s1_keep_q   <= s1_keep_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      s1_eof_q    <= s1_eof_d;
      s1_vc_q     <= s1_vc_d;
      s1_err_q    <= s1_err_d;
      out_vld     <= s1_vld_q;
      out_dat     <= s1_dat_q;
      out_keep    <= s1_keep_q;
      out_sof     <= s1_sof_q;
      out_eol     <= s1_eol_q;
      out_eof     <= s1_eof_q;
      err         <= s1_err_q;
      if (s1_vld_q || s1_eof_q) out_vc <= s1_vc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pkt) state_d = PAYLOAD;
      PAYLOAD: begin
        if (hdr_ok)         state_d = start_pkt ? PAYLOAD : IDLE;
        else if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_vc_d    = pkt_vc_q;
    pkt_wc_d    = pkt_wc_q;
    beats_d     = beats_q;
    pkt_act_d   = pkt_act_q;
    pkt_en_d    = pkt_en_q;
    in_frame_d  = in_frame_q;
    sof_pend_d  = sof_pend_q;
    en_d        = en_q;
    line_cnt_d  = line_cnt_q;
    first_len_d = first_len_q;
    img_h_d     = img_h_q;
    img_v_d     = img_v_q;
    skip_d      = skip_q;
    s1_vld_d    = 1'b0;
    s1_dat_d    = '0;
    s1_keep_d   = '0;
    s1_sof_d    = 1'b0;
    s1_eol_d    = 1'b0;
    s1_eof_d    = 1'b0;
    s1_vc_d     = s1_vc_q;
    s1_err_d    = '0;
    rem         = pkt_wc_q % 16'(BYTES);
    beats_new   = 16'(({1'b0, hdr_wc} + 17'(BYTES - 1)) / 17'(BYTES));
    for (int b = 0; b < BYTES; b++) last_keep[b] = (rem == 16'd0) || (b < int'(rem));

    if (beat) begin
      beats_d = beats_q - 16'd1;
      if (pkt_en_q) begin
        s1_vld_d  = 1'b1;
        s1_dat_d  = dat_i;
        s1_keep_d = last_beat ? last_keep : '1;
        s1_eol_d  = last_beat;
        s1_vc_d   = pkt_vc_q;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (pkt_vc_q == v[1:0]) begin
          if (pkt_en_q) begin
            s1_sof_d      = sof_pend_q[v];
            sof_pend_d[v] = 1'b0;
          end
          if (last_beat && pkt_act_q) begin
            if (line_cnt_q[v] != '1)   line_cnt_d[v]  = line_cnt_q[v] + CNT_W'(1);
            if (line_cnt_q[v] == '0)   first_len_d[v] = CNT_W'(pkt_wc_q);
          end
        end
      end
    end

    if (hdr_ok) begin
      if (state_q == PAYLOAD) s1_err_d[0] = 1'b1;
      if (start_pkt) begin
        pkt_vc_d = hdr_vc;
        pkt_wc_d = hdr_wc;
        beats_d  = beats_new;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (hdr_vc == v[1:0]) begin
          if (is_fs) begin
            if (in_frame_q[v]) s1_err_d[2] = 1'b1;
            in_frame_d[v]  = 1'b1;
            line_cnt_d[v]  = '0;
            first_len_d[v] = '0;
            sof_pend_d[v]  = 1'b1;
            en_d[v]        = (skip_q[v] == SKW'(SKIP_FRAMES));
          end else if (is_fe && in_frame_q[v]) begin
            in_frame_d[v] = 1'b0;
            img_v_d[v]    = line_cnt_q[v];
            img_h_d[v]    = first_len_q[v];
            if (skip_q[v] != SKW'(SKIP_FRAMES)) skip_d[v] = skip_q[v] + SKW'(1);
            if (en_q[v]) begin
              s1_eof_d = 1'b1;
              s1_vc_d  = hdr_vc;
            end
          end
          if (start_pkt) begin
            pkt_act_d = in_frame_q[v];
            pkt_en_d  = in_frame_q[v] && en_q[v];
            if (in_frame_q[v] && (line_cnt_q[v] != '0) && (first_len_q[v] != CNT_W'(hdr_wc)))
              s1_err_d[1] = 1'b1;
          end
        end
      end
    end
  end

  assign img_hbytes = img_h_q;
  assign img_vlines = img_v_q;

endmodule

// File: doc/csi_frame_fmt.md
Name: csi_frame_fmt

Overview:
- Parametrised successor to the CSI-2 frame-data formatter.
- Takes decoded packet headers and payload beats from the lane/ECC stage and emits a framed pixel stream with SOF/EOL markers, per-byte keep and a separate EOF pulse.
- Supports up to 4 virtual channels, with per-VC start-up frame skipping, per-VC frame-size measurement and packet-integrity error flags.
- Sits between the ECC/header decoder and the frame-buffer write FIFO.

Parameters:
DATA_W, 32, payload beat width in bits; multiple of 8, range 16..128; BYTES = DATA_W/8
NUM_VC, 1, number of virtual channels tracked (1..4)
SKIP_FRAMES, 4, complete frames per VC dropped after reset before output is enabled (0 = none)
CNT_W, 16, width of line/byte counters and measurement outputs

Ports:
pixel_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
hdr_vld  in  1  one-cycle pulse: packet header decoded and ECC-checked
hdr_dt  in  6  data type of header
hdr_vc  in  2  virtual channel of header
hdr_wc  in  16  word count (payload bytes) of a long packet
dat_vld  in  1  payload beat valid
dat_i  in  DATA_W  payload beat, byte 0 in bits [7:0]
out_vld  out  1  output beat valid
out_dat  out  DATA_W  output beat
out_keep  out  BYTES  valid-byte mask of out_dat
out_sof  out  1  first beat of a frame (qualifies out_vld)
out_eol  out  1  last beat of a line (qualifies out_vld)
out_eof  out  1  one-cycle frame-end pulse; out_vld is low in that cycle
out_vc  out  2  VC of current output cycle
img_hbytes  out  NUM_VC*CNT_W  per-VC bytes per line of last complete frame
img_vlines  out  NUM_VC*CNT_W  per-VC line count of last complete frame
err  out  3  one-cycle pulses: [0] truncated packet, [1] line length mismatch, [2] FS without FE

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; all counters 0; every VC enters WAIT_FS; packet FSM enters IDLE.
- Header classification:
  - DT 0x00 = FS; DT 0x01 = FE.
  - DT 0x02..0x0F = other short packet, ignored.
  - DT >= 0x10 = long packet (line).
  - Headers with hdr_vc >= NUM_VC are ignored entirely.
- Packet FSM:
  - IDLE -> PAYLOAD on a long-packet header with hdr_wc != 0. On entry, latch vc and wc; beats_left = ceil(wc/BYTES).
  - A long packet with wc = 0 is ignored.
  - In PAYLOAD each dat_vld decrements beats_left; the beat reaching 0 returns the FSM to IDLE.
  - dat_vld in IDLE is ignored.
  - hdr_vld and dat_vld in the same cycle: dat_vld is ignored and the header is processed.
- Truncation:
  - A hdr_vld arriving in PAYLOAD with beats_left != 0 pulses err[0].
  - The current line ends without out_eol and is not counted.
  - The new header is then processed normally in the same cycle.
- Per-VC frame FSM:
  - WAIT_FS -> IN_FRAME on FS; this clears line_cnt and first_len and arms sof_pend.
  - IN_FRAME -> WAIT_FS on FE.
  - FS while IN_FRAME pulses err[2] and restarts the frame (counters cleared, sof_pend re-armed).
  - FE while in WAIT_FS is ignored.
  - Long packets on a VC in WAIT_FS are consumed but produce no output and are not counted.
- Measurement:
  - Each completed line increments line_cnt (saturates at all-ones).
  - The first line of a frame stores first_len = wc. Each later line with wc != first_len pulses err[1]; the line is still output.
  - On FE from IN_FRAME: img_vlines[vc] <= line_cnt and img_hbytes[vc] <= first_len. Values are held until the next FE on that VC.
- Skip:
  - Per-VC skip_cnt increments on each FE from IN_FRAME and saturates at SKIP_FRAMES.
  - Output for a VC is enabled only when skip_cnt == SKIP_FRAMES, sampled at that frame's FS.
  - A frame in progress is never partially output.
  - Measurement runs on skipped frames too.
- Output timing:
  - Latency is exactly 2 cycles from dat_vld (accepted beat) to out_vld, and from FE hdr_vld to out_eof.
  - out_sof is set on the first output beat after FS (sof_pend), then sof_pend clears.
  - out_eol is set on the beat where beats_left reaches 0.
  - out_keep is all ones except on the last beat of a line: bits [r-1:0] set, where r = wc mod BYTES (r = 0 gives all ones).
  - out_dat passes through unmodified; bytes outside out_keep are don't-care.
  - The out_vc register updates with every out_vld or out_eof cycle and holds otherwise.
- Errors pulse 2 cycles after the triggering header, aligned to the output pipeline.
- Asserting reset_n low mid-packet aborts immediately with no trailing output.

Test Plan:
- DATA_W=32, SKIP_FRAMES=0, VC0: FS, 3 lines wc=8, FE -> 6 out_vld beats; out_sof on beat 1; out_eol on beats 2/4/6; out_eof 2 cycles after FE; img_vlines[0]=3, img_hbytes[0]=8.
- DATA_W=64, wc=13 -> 2 beats; last beat out_keep=8'h1F with out_eol; first beat out_keep=8'hFF.
- SKIP_FRAMES=2: send 3 frames -> frames 1-2 produce no out_vld, but img_vlines updates after each FE; frame 3 output fully with out_sof.
- wc=16, header arrives after 2 of 4 beats -> err[0] pulse; no out_eol for that line; line_cnt unchanged; next line is output normally.
- NUM_VC=2: interleave VC0 and VC1 frames with line lengths 8 and 12 -> out_vc matches per beat; img_hbytes = {12, 8}. A line of wc=10 in the VC0 frame gives an err[1] pulse. FS on VC1 without FE gives an err[2] pulse.
- Assert reset_n mid-payload -> all outputs 0 within the same cycle; after release, data before the first FS is ignored.
